// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and load/store stages.
// All three sides use two-phase (toggle) request/acknowledge handshakes.
// Arbitration favours data, but a pending fetch gets the port after
// DATA_STREAK_MAX consecutive data grants.
// Latency: a request sampled in IDLE toggles mem_req on that same edge. A
// completion sampled in WAIT toggles the requester's ack on that same edge.
// Backpressure: one transaction is outstanding at a time. Requests that arrive
// during WAIT stay pending and are arbitrated in the next IDLE cycle.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   if_req/if_addr        fetch request toggle and address
//   if_ack/if_rdata       fetch ack toggle and captured read data
//   dm_req/dm_we/dm_addr/dm_wdata  data request toggle and command
//   dm_ack/dm_rdata       data ack toggle and captured read data
//   mem_req/mem_we/mem_addr/mem_wdata  memory command, held until completion
//   mem_ack/mem_rdata     memory completion toggle and read data
//   busy/owner            transaction outstanding, and its owner (1 = data)
//   proto_err             sticky flag: mem_ack moved while nothing was outstanding
module mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DATA_STREAK_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic              proto_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              owner_q, owner_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              proto_err_q, proto_err_d;

  logic if_pend;
  logic dm_pend;
  logic grant_dm;

  assign if_pend = if_req ^ if_ack_q;
  assign dm_pend = dm_req ^ dm_ack_q;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    if_ack_d    = if_ack_q;
    dm_ack_d    = dm_ack_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    proto_err_d = proto_err_q;
    grant_dm    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // While idle the memory has nothing to acknowledge. Any mismatch is
        // flagged, but it does not block arbitration.
        if (mem_ack != mem_req_q) begin
          proto_err_d = 1'b1;
        end
        if (if_pend || dm_pend) begin
          // Data wins unless a fetch has waited through the full streak.
          grant_dm  = dm_pend && (!if_pend || (streak_q != STREAK_MAX));
          mem_req_d = ~mem_req_q;
          owner_d   = grant_dm;
          state_d   = ST_WAIT;
          if (grant_dm) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            // The streak only counts data grants that held off a waiting fetch.
            if (if_pend) begin
              streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
            end else begin
              streak_d = 4'd0;
            end
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = 4'd0;
          end
        end
      end
      ST_WAIT: begin
        if (mem_ack == mem_req_q) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            dm_ack_d = ~dm_ack_q;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = ~if_ack_q;
            if_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == ST_WAIT);
  assign owner     = owner_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
  logic          owner;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model, evaluated on each rising edge from the sampled inputs.
  logic          m_if_ack = 0, m_dm_ack = 0, m_mem_req = 0, m_mem_we = 0;
  logic          m_busy = 0, m_owner = 0, m_perr = 0;
  logic [AW-1:0] m_mem_addr = 0;
  logic [DW-1:0] m_mem_wdata = 0, m_if_rdata = 0, m_dm_rdata = 0;
  int            m_streak = 0;

  always @(posedge clk) begin : model
    bit ip, dp, dw;
    if (reset) begin
      m_if_ack = 0; m_dm_ack = 0; m_mem_req = 0; m_mem_we = 0;
      m_busy = 0; m_owner = 0; m_perr = 0;
      m_mem_addr = 0; m_mem_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
      m_streak = 0;
    end else if (!m_busy) begin
      if (mem_ack != m_mem_req) m_perr = 1;
      ip = (if_req != m_if_ack);
      dp = (dm_req != m_dm_ack);
      if (ip || dp) begin
        dw = dp && !(ip && m_streak == SMAX);
        m_owner     = dw;
        m_busy      = 1;
        m_mem_req   = !m_mem_req;
        m_mem_we    = dw ? dm_we : 1'b0;
        m_mem_addr  = dw ? dm_addr : if_addr;
        m_mem_wdata = dw ? dm_wdata : '0;
        if (dw && ip) m_streak = (m_streak + 1 > SMAX) ? SMAX : m_streak + 1;
        else          m_streak = 0;
      end
    end else if (mem_ack == m_mem_req) begin
      m_busy = 0;
      if (!m_owner) begin
        m_if_ack = !m_if_ack;
        m_if_rdata = mem_rdata;
      end else begin
        m_dm_ack = !m_dm_ack;
        if (!m_mem_we) m_dm_rdata = mem_rdata;
      end
    end
  end

  // Per-cycle compare against the model, plus a log of grant owners.
  int   grants[$];
  logic prev_mem_req = 0;

  always @(negedge clk) begin
    chk("if_ack",    if_ack,    m_if_ack);
    chk("dm_ack",    dm_ack,    m_dm_ack);
    chk("mem_req",   mem_req,   m_mem_req);
    chk("mem_we",    mem_we,    m_mem_we);
    chk("mem_addr",  mem_addr,  m_mem_addr);
    chk("mem_wdata", mem_wdata, m_mem_wdata);
    chk("if_rdata",  if_rdata,  m_if_rdata);
    chk("dm_rdata",  dm_rdata,  m_dm_rdata);
    chk("busy",      busy,      m_busy);
    chk("proto_err", proto_err, m_perr);
    if (m_busy) chk("owner", owner, m_owner);
    else        chk("owner_after_reset_or_hold", owner, m_owner);
    if (mem_req != prev_mem_req && !reset) grants.push_back(int'(owner));
    prev_mem_req = mem_req;
  end

  // Stimulus: every input is driven from here, just after a falling edge.
  bit mem_auto = 0;
  bit req_auto = 0;
  int mem_dly  = 0;

  task automatic step();
    @(negedge clk);
    if (mem_auto && (mem_req != mem_ack)) begin
      if (mem_dly == 0) begin
        mem_rdata = $urandom;
        mem_ack   = mem_req;
        mem_dly   = $urandom_range(0, 3);
      end else begin
        mem_dly--;
      end
    end
    if (req_auto) begin
      if (if_req == if_ack && $urandom_range(0, 2) == 0) begin
        if_addr = $urandom;
        if_req  = !if_req;
      end
      if (dm_req == dm_ack && $urandom_range(0, 2) == 0) begin
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = $urandom;
        dm_wdata = $urandom;
        dm_req   = !dm_req;
      end
    end
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{1, 1, 0, 1, 1, 0};

    repeat (3) step();
    reset = 0;
    chk("rst_if_ack", if_ack, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    step();

    // Single fetch
    if_addr = 32'h10; if_req = 1;
    step();
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_addr", mem_addr, 32'h10);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_owner", owner, 0);
    repeat (2) step();
    mem_rdata = 32'hE3A00001; mem_ack = 1;
    step();
    chk("fetch_if_ack", if_ack, 1);
    chk("fetch_if_rdata", if_rdata, 32'hE3A00001);
    chk("fetch_model_rdata", m_if_rdata, 32'hE3A00001);
    chk("fetch_dm_ack", dm_ack, 0);
    chk("fetch_busy_clr", busy, 0);

    // Data write
    dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_req = 1;
    step();
    chk("wr_mem_req", mem_req, 0);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h200);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_owner", owner, 1);
    mem_rdata = 32'h5A5A5A5A; mem_ack = 0;
    step();
    chk("wr_dm_ack", dm_ack, 1);
    chk("wr_dm_rdata", dm_rdata, 0);
    chk("wr_if_ack", if_ack, 1);

    // Spurious ack in IDLE, toggled and then restored
    mem_ack = 1;
    step();
    chk("perr_set", proto_err, 1);
    mem_ack = 0;
    step();
    chk("perr_sticky", proto_err, 1);
    if_addr = 32'h44; if_req = 0;
    step();
    chk("perr_fetch_issue", mem_req, 1);
    chk("perr_fetch_addr", mem_addr, 32'h44);
    mem_rdata = 32'h12345678; mem_ack = 1;
    step();
    chk("perr_fetch_ack", if_ack, 0);
    chk("perr_fetch_rdata", if_rdata, 32'h12345678);
    chk("perr_still", proto_err, 1);

    // Data request arriving while a fetch is outstanding
    if_addr = 32'h80; if_req = 1;
    step();
    chk("wait_fetch_issue", mem_req, 0);
    step();
    dm_we = 0; dm_addr = 32'h300; dm_req = 0;
    repeat (2) step();
    chk("wait_still_busy", busy, 1);
    mem_rdata = 32'hAAAA5555; mem_ack = 0;
    step();
    chk("wait_if_ack", if_ack, 1);
    chk("wait_no_early_grant", mem_req, 0);
    chk("wait_idle", busy, 0);
    step();
    chk("wait_data_grant", mem_req, 1);
    chk("wait_data_owner", owner, 1);
    chk("wait_data_addr", mem_addr, 32'h300);
    mem_rdata = 32'h0BADF00D; mem_ack = 1;
    step();
    chk("wait_dm_ack", dm_ack, 0);
    chk("wait_dm_rdata", dm_rdata, 32'h0BADF00D);

    // Reset with a fetch outstanding
    if_addr = 32'h90; if_req = 0;
    step();
    chk("rw_busy", busy, 1);
    reset = 1; if_req = 0; dm_req = 0; mem_ack = 0;
    step();
    reset = 0;
    chk("rw_zero", {if_ack, dm_ack, mem_req, mem_we, busy, owner, proto_err}, 0);
    chk("rw_zero_addr", mem_addr, 0);
    chk("rw_zero_wdata", mem_wdata, 0);
    chk("rw_zero_rdata", {if_rdata, dm_rdata}, 0);
    if_addr = 32'h14; if_req = 1;
    step();
    chk("rw_new_issue", mem_req, 1);
    mem_rdata = 32'hCAFE0001; mem_ack = 1;
    step();
    chk("rw_new_ack", if_ack, 1);
    chk("rw_new_rdata", if_rdata, 32'hCAFE0001);

    // Contention: both requesters re-request as soon as they are acked
    mem_auto = 1;
    grants.delete();
    begin
      int n = 0;
      while (grants.size() < 6 && n < 300) begin
        step();
        if (if_req == if_ack) begin if_addr = $urandom; if_req = !if_req; end
        if (dm_req == dm_ack) begin
          dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
          dm_req = !dm_req;
        end
        n++;
      end
      if (grants.size() < 6) chk("contention_timeout", grants.size(), 6);
      else for (int i = 0; i < 6; i++) chk($sformatf("grant_order_%0d", i), grants[i], exp_order[i]);
    end
    repeat (20) step();

    // Randomised traffic against the model
    req_auto = 1;
    repeat (3000) step();
    req_auto = 0;
    begin
      int n = 0;
      while ((busy || if_req != if_ack || dm_req != dm_ack) && n < 100) begin
        step();
        n++;
      end
      chk("drain_idle", {busy, if_req ^ if_ack, dm_req ^ dm_ack}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
